// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue controller: ALU opcodes, MIPS opcode/funct
// values, FSM state type and response flag positions.
package alu_pkg;

  localparam logic [2:0] AluAnd  = 3'b000;
  localparam logic [2:0] AluOr   = 3'b001;
  localparam logic [2:0] AluAdd  = 3'b010;
  localparam logic [2:0] AluSltu = 3'b011;
  localparam logic [2:0] AluSll  = 3'b100;
  localparam logic [2:0] AluLu   = 3'b101;
  localparam logic [2:0] AluSub  = 3'b110;
  localparam logic [2:0] AluSlt  = 3'b111;

  localparam logic [5:0] OpcRtype = 6'h00;
  localparam logic [5:0] OpcAddi  = 6'h08;
  localparam logic [5:0] OpcAddiu = 6'h09;
  localparam logic [5:0] OpcSlti  = 6'h0a;
  localparam logic [5:0] OpcSltiu = 6'h0b;
  localparam logic [5:0] OpcAndi  = 6'h0c;
  localparam logic [5:0] OpcOri   = 6'h0d;
  localparam logic [5:0] OpcLui   = 6'h0f;

  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnSlt  = 6'h2a;
  localparam logic [5:0] FnSltu = 6'h2b;

  localparam int unsigned FlagZero  = 0;
  localparam int unsigned FlagCarry = 1;
  localparam int unsigned FlagOvf   = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDecode = 2'd1,
    StExec   = 2'd2,
    StResp   = 2'd3
  } issueStateE;

endpackage

// File: rtl/alu_inst_decode.sv
// Combinational MIPS decoder: maps an instruction and its operands onto
// ALU op/A/B, destination register and illegal/signed-arith indications.
module alu_inst_decode
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [31:0]           inst,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  output logic [2:0]            op,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic [4:0]            dest,
  output logic                  illegal,
  output logic                  isSignedArith
);

  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] immSext;
  logic [DATA_WIDTH-1:0] immZext;
  logic [DATA_WIDTH-1:0] shamt;

  assign opcode  = inst[31:26];
  assign funct   = inst[5:0];
  // Size casts sign/zero-extend, or truncate when DATA_WIDTH is below 16.
  assign immSext = DATA_WIDTH'($signed(inst[15:0]));
  assign immZext = DATA_WIDTH'(inst[15:0]);
  assign shamt   = DATA_WIDTH'(inst[10:6]);

  always_comb begin
    op            = AluAnd;
    a             = rs;
    b             = rt;
    dest          = (opcode == OpcRtype) ? inst[15:11] : inst[20:16];
    illegal       = 1'b0;
    isSignedArith = 1'b0;
    case (opcode)
      OpcRtype: begin
        case (funct)
          FnAnd:  op = AluAnd;
          FnOr:   op = AluOr;
          FnAdd:  begin op = AluAdd; isSignedArith = 1'b1; end
          FnAddu: op = AluAdd;
          FnSub:  begin op = AluSub; isSignedArith = 1'b1; end
          FnSubu: op = AluSub;
          FnSlt:  op = AluSlt;
          FnSltu: op = AluSltu;
          FnSll:  begin op = AluSll; a = shamt; end
          default: illegal = 1'b1;
        endcase
      end
      OpcAddi:  begin op = AluAdd; b = immSext; isSignedArith = 1'b1; end
      OpcAddiu: begin op = AluAdd; b = immSext; end
      OpcSlti:  begin op = AluSlt; b = immSext; end
      OpcSltiu: begin op = AluSltu; b = immSext; end
      OpcAndi:  begin op = AluAnd; b = immZext; end
      OpcOri:   begin op = AluOr; b = immZext; end
      OpcLui:   begin op = AluLu; a = '0; b = immZext; end
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller in front of the alu: accepts an instruction,
// drives registered A/B/ALUop, captures Result/flags and returns a response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  input  logic [31:0]           inst,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Zero,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic [2:0]            rsp_flags,
  output logic [4:0]            rsp_dest,
  output logic                  rsp_wen,
  output logic                  rsp_illegal,
  output logic                  rsp_ovf_trap
);

  issueStateE            stateQ, stateD;
  logic [31:0]           instQ;
  logic [DATA_WIDTH-1:0] rsQ, rtQ;
  logic                  accept;
  logic                  trap;

  logic [2:0]            decOp;
  logic [DATA_WIDTH-1:0] decA, decB;
  logic [4:0]            decDest;
  logic                  decIllegal, decSigned;

  // Decoder sees the captured instruction, which is stable through DECODE and EXEC.
  alu_inst_decode #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_decode (
    .inst         (instQ),
    .rs           (rsQ),
    .rt           (rtQ),
    .op           (decOp),
    .a            (decA),
    .b            (decB),
    .dest         (decDest),
    .illegal      (decIllegal),
    .isSignedArith(decSigned)
  );

  assign accept = (stateQ == StIdle) && inst_valid && inst_ready;
  assign trap   = decSigned && alu_Overflow;

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:   if (accept) stateD = StDecode;
      StDecode: stateD = decIllegal ? StResp : StExec;
      StExec:   stateD = StResp;
      StResp:   if (rsp_ready) stateD = StIdle;
      default:  stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ       <= StIdle;
      instQ        <= '0;
      rsQ          <= '0;
      rtQ          <= '0;
      inst_ready   <= 1'b0;
      rsp_valid    <= 1'b0;
      alu_A        <= '0;
      alu_B        <= '0;
      alu_op       <= '0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      rsp_dest     <= '0;
      rsp_wen      <= 1'b0;
      rsp_illegal  <= 1'b0;
      rsp_ovf_trap <= 1'b0;
    end else begin
      stateQ     <= stateD;
      // Handshake flags follow the next state so they change on the same edge.
      inst_ready <= (stateD == StIdle);
      rsp_valid  <= (stateD == StResp);
      if (accept) begin
        instQ <= inst;
        rsQ   <= rs_data;
        rtQ   <= rt_data;
      end
      if (stateQ == StDecode) begin
        if (decIllegal) begin
          rsp_result   <= '0;
          rsp_flags    <= '0;
          rsp_dest     <= decDest;
          rsp_wen      <= 1'b0;
          rsp_illegal  <= 1'b1;
          rsp_ovf_trap <= 1'b0;
        end else begin
          alu_A  <= decA;
          alu_B  <= decB;
          alu_op <= decOp;
        end
      end
      if (stateQ == StExec) begin
        rsp_result           <= alu_Result;
        rsp_flags[FlagZero]  <= alu_Zero;
        rsp_flags[FlagCarry] <= alu_CarryOut;
        rsp_flags[FlagOvf]   <= alu_Overflow;
        rsp_dest             <= decDest;
        rsp_wen              <= !trap && (decDest != 5'd0);
        rsp_illegal          <= 1'b0;
        rsp_ovf_trap         <= trap;
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue controller that sits in front of the `alu` block and drives it. It accepts one MIPS-style instruction plus its register operands over a valid/ready handshake and decodes it into `ALUop`, `A` and `B`. It captures `Result`, `Zero`, `CarryOut` and `Overflow` from the ALU, then returns a registered response over a second valid/ready handshake. It is the initiator side of the ALU's `A/B/ALUop → Result/flags` interface.

## Interface
Parameters:
- DATA_WIDTH, 32, ALU datapath width. Must match the attached `alu`. `lui` semantics are exact only at 32.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- inst_valid  in  1  instruction offered
- inst_ready  out  1  controller can accept
- inst  in  32  instruction word
- rs_data  in  DATA_WIDTH  rs operand, sampled with inst
- rt_data  in  DATA_WIDTH  rt operand, sampled with inst
- alu_A  out  DATA_WIDTH  to ALU A (registered)
- alu_B  out  DATA_WIDTH  to ALU B (registered)
- alu_op  out  3  to ALU ALUop (registered)
- alu_Result  in  DATA_WIDTH  from ALU
- alu_Zero, alu_CarryOut, alu_Overflow  in  1 each  ALU flags
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_result  out  DATA_WIDTH  captured Result
- rsp_flags  out  3  {Overflow, CarryOut, Zero}
- rsp_dest  out  5  destination register
- rsp_wen  out  1  result should be written
- rsp_illegal  out  1  unsupported instruction
- rsp_ovf_trap  out  1  signed add/sub overflowed

## Operation
- ALUop encoding: AND=000, OR=001, ADD=010, SLTU=011, SLL=100, LU=101, SUB=110, SLT=111.
- R-type (opcode 0), funct → op/A/B:
  - 0x24 and, 0x25 or: A=rs, B=rt.
  - 0x20 add, 0x21 addu → ADD; 0x22 sub, 0x23 subu → SUB; 0x2a slt → SLT; 0x2b sltu → SLTU. All with A=rs, B=rt.
  - 0x00 sll → SLL, A=zero-extended shamt (inst[10:6]), B=rt.
  - dest=rd.
- I-type, dest=rt, imm=inst[15:0]:
  - 0x08 addi, 0x09 addiu → ADD, sign-extended imm.
  - 0x0a slti → SLT, sign-extended imm.
  - 0x0b sltiu → SLTU, sign-extended imm.
  - 0x0c andi → AND, zero-extended imm.
  - 0x0d ori → OR, zero-extended imm.
  - 0x0f lui → LU, A=0, B=zero-extended imm.
  - Widths below 32 truncate imm to the low DATA_WIDTH bits.
- Any other opcode or funct: rsp_illegal=1, rsp_result=0, rsp_flags=0, rsp_wen=0. The ALU outputs are not sampled.
- rsp_ovf_trap=alu_Overflow only for add, sub and addi; otherwise 0.
- rsp_wen = !illegal && !ovf_trap && dest!=0.
- FSM states:
  - IDLE: inst_ready=1. On inst_valid, go to DECODE.
  - DECODE: register alu_A/alu_B/alu_op, or go straight to RESP if illegal.
  - EXEC: ALU settles combinationally; capture Result/flags at the end of the cycle. Go to RESP.
  - RESP: rsp_valid=1. Stay until rsp_ready, then go to IDLE.
- inst, rs_data and rt_data are registered on the accept edge. Later changes on the inputs have no effect.
- alu_A/alu_B/alu_op hold their values after EXEC until the next DECODE.
- rsp_* fields are stable while rsp_valid=1 and rsp_ready=0.

## Timing
- All outputs are registered and are 0 during and after reset: inst_ready=0 while rst=1, and 1 on the first cycle in IDLE after reset.
- Accept at edge E0. alu_* valid from E1. Result captured at E2. rsp_valid=1 from E2 on.
- Legal-instruction latency: accept → rsp_valid is 3 edges. Illegal instruction: 2 edges.
- The rsp handshake completes at the edge where rsp_valid && rsp_ready. rsp_valid drops and inst_ready rises at that same edge. Minimum spacing is 4 cycles per legal instruction.
- No accept while busy: inst_ready=0 outside IDLE.
- rst asserted in any state: at the next edge the FSM returns to IDLE and all outputs are 0. An in-flight instruction or response is discarded with no partial rsp_valid.
- rst has priority over every handshake event in the same cycle.

## Structure
- Package `alu_pkg`:
  - ALUop localparams.
  - Opcode and funct constants.
  - FSM state encoding (2-bit).
  - Flag bit positions within rsp_flags.
- Sub-module `alu_inst_decode`: purely combinational. Takes inst, rs and rt; produces op, A, B, dest, illegal and is_signed_arith. The top level holds only the FSM and registers.

## Test plan
- addu: rs=5, rt=3, with rsp_ready held 1 → rsp_valid 3 edges after accept; result=8, flags=000, dest=rd, wen=1.
- sub: rs=0x80000000, rt=1 → result=0x7FFFFFFF, ovf_trap=1, wen=0. subu with the same operands → ovf_trap=0, wen=1.
- lui: imm 0x1234 → alu_op=101, result=0x12340000. sll: shamt=4, rt=0x1 → result=0x10.
- sltu: rs=1, rt=0xFFFFFFFF → result=1. slt on the same operands → result=0. slti rs=-2, imm=0xFFFF → result=1.
- Illegal opcode 0x3f → rsp_illegal=1 after 2 edges, result=0, alu_* unchanged from the previous instruction.
- Backpressure and reset:
  - rsp_ready=0 for 5 cycles → rsp_* held stable, inst_ready=0 throughout.
  - rst pulsed in EXEC → next cycle IDLE, all outputs 0, no response emitted.
